// File: rtl/shift_add_pipe_if.sv
// rtl/shift_add_pipe_if.sv - valid/ready operand vector and result bundle for shift_add_pipe
interface shift_add_pipe_if #(
    parameter int NUM_INPUTS = 4,
    parameter int BIT_WIDTH  = 8,
    parameter int SHIFT_STEP = 1
);
    localparam int MAX_SHIFT     = (NUM_INPUTS - 1) * SHIFT_STEP;
    localparam int LEVELS        = $clog2(NUM_INPUTS);
    localparam int OUT_BIT_WIDTH = BIT_WIDTH + MAX_SHIFT + LEVELS;
    localparam int LANE_W        = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    logic [NUM_INPUTS-1:0][BIT_WIDTH-1:0] in;
    logic                                 disable_stage;
    logic                                 in_valid;
    logic                                 in_ready;
    logic [OUT_BIT_WIDTH-1:0]             out;
    logic [LANE_W-1:0]                    out_lane;
    logic                                 out_bypass;
    logic                                 out_valid;
    logic                                 out_ready;

    modport master (
        output in, disable_stage, in_valid, out_ready,
        input  in_ready, out, out_lane, out_bypass, out_valid
    );

    modport slave (
        input  in, disable_stage, in_valid, out_ready,
        output in_ready, out, out_lane, out_bypass, out_valid
    );
endinterface

// File: rtl/shift_add_pipe.sv
// rtl/shift_add_pipe.sv - pipelined shift-and-add reduce / serial bypass stage (optional SHIFT_ADD_PIPE_PERF_EN vector counter)
module shift_add_pipe #(
    parameter int NUM_INPUTS = 4,
    parameter int BIT_WIDTH  = 8,
    parameter int SHIFT_STEP = 1
) (
    input  logic clk,
    input  logic rst_n,
`ifdef SHIFT_ADD_PIPE_PERF_EN
    output logic [15:0] vec_count,
`endif
    shift_add_pipe_if.slave bus
);
    localparam int MAX_SHIFT = (NUM_INPUTS - 1) * SHIFT_STEP;
    localparam int LEVELS    = $clog2(NUM_INPUTS);
    localparam int OUT_W     = BIT_WIDTH + MAX_SHIFT + LEVELS;
    localparam int LANE_W    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int LEAVES    = 1 << LEVELS;

    typedef enum logic [1:0] {IDLE, REDUCE, SERIAL} state_t;

    state_t                               state;
    state_t                               state_nxt;
    logic                                 init_done;
    logic                                 advance;
    logic                                 accept;
    logic                                 accept_reduce;
    logic                                 accept_serial;
    logic                                 pipe_busy;
    logic                                 last_lane;
    logic [LEVELS:0]                      vld;
    logic [OUT_W-1:0]                     tree [LEVELS+1][LEAVES];
    logic [OUT_W-1:0]                     term [LEAVES];
    logic [NUM_INPUTS-1:0][BIT_WIDTH-1:0] lanes;
    logic [LANE_W-1:0]                    lane_k;
    logic [LANE_W-1:0]                    lane_nxt;

    // Sign-extend each lane, then weight it by its lane position; padded leaves stay zero
    always_comb begin
        for (int i = 0; i < LEAVES; i++) begin
            term[i] = '0;
        end
        for (int i = 0; i < NUM_INPUTS; i++) begin
            term[i] = OUT_W'($signed(bus.in[i])) << (i * SHIFT_STEP);
        end
    end

    // Handshake decode and next-state logic; a whole-pipeline stall is driven by the output slot
    always_comb begin
        advance       = !bus.out_valid || bus.out_ready;
        last_lane     = (lane_k == LANE_W'(NUM_INPUTS - 1));
        lane_nxt      = lane_k + 1'b1;
        pipe_busy     = (|vld) || bus.out_valid;
        bus.in_ready  = 1'b0;
        state_nxt     = state;
        case (state)
            IDLE:    bus.in_ready = init_done;
            REDUCE:  bus.in_ready = advance && !bus.disable_stage;
            default: bus.in_ready = 1'b0;
        endcase
        accept        = bus.in_valid && bus.in_ready;
        accept_reduce = accept && !bus.disable_stage;
        accept_serial = accept && bus.disable_stage;
        case (state)
            IDLE: begin
                if (accept_reduce) begin
                    state_nxt = REDUCE;
                end else if (accept_serial) begin
                    state_nxt = SERIAL;
                end
            end
            REDUCE: begin
                if (!accept && !pipe_busy) begin
                    state_nxt = IDLE;
                end
            end
            SERIAL: begin
                if (bus.out_valid && bus.out_ready && last_lane) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Hold off input acceptance until the first clock after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b1;
        end
    end

    // Term register plus pairwise adder levels; every stage moves together or holds together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= '0;
            tree <= '{default: '0};
        end else if (advance) begin
            vld[0] <= accept_reduce;
            if (accept_reduce) begin
                for (int i = 0; i < LEAVES; i++) begin
                    tree[0][i] <= term[i];
                end
            end
            for (int l = 1; l <= LEVELS; l++) begin
                vld[l] <= vld[l-1];
                for (int j = 0; j < (LEAVES >> l); j++) begin
                    tree[l][j] <= tree[l-1][2*j] + tree[l-1][2*j+1];
                end
            end
        end
    end

    // Output slot: fed by the tree root in reduce/idle, by the latched vector one lane at a time in serial
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out        <= '0;
            bus.out_lane   <= '0;
            bus.out_bypass <= 1'b0;
            bus.out_valid  <= 1'b0;
            lanes          <= '0;
            lane_k         <= '0;
        end else begin
            if (accept_serial) begin
                lanes  <= bus.in;
                lane_k <= '0;
            end
            if (state == SERIAL) begin
                if (!bus.out_valid) begin
                    bus.out        <= OUT_W'(lanes[lane_k]);
                    bus.out_lane   <= lane_k;
                    bus.out_bypass <= 1'b1;
                    bus.out_valid  <= 1'b1;
                end else if (bus.out_ready) begin
                    if (last_lane) begin
                        bus.out_valid  <= 1'b0;
                        bus.out_bypass <= 1'b0;
                        bus.out_lane   <= '0;
                        lane_k         <= '0;
                    end else begin
                        bus.out      <= OUT_W'(lanes[lane_nxt]);
                        bus.out_lane <= lane_nxt;
                        lane_k       <= lane_nxt;
                    end
                end
            end else if (advance) begin
                bus.out        <= tree[LEVELS][0];
                bus.out_lane   <= '0;
                bus.out_bypass <= 1'b0;
                bus.out_valid  <= vld[LEVELS];
            end
        end
    end

`ifdef SHIFT_ADD_PIPE_PERF_EN
    // Count accepted vectors of either mode, wrapping at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_count <= '0;
        end else if (accept) begin
            vec_count <= vec_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_shift_add_pipe.sv
// tb/tb_shift_add_pipe.sv - directed self-checking bench for shift_add_pipe
module tb_shift_add_pipe;
    localparam int N  = 4;
    localparam int BW = 8;
    localparam int SS = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    shift_add_pipe_if #(.NUM_INPUTS(N), .BIT_WIDTH(BW), .SHIFT_STEP(SS)) bus ();

`ifdef SHIFT_ADD_PIPE_PERF_EN
    logic [15:0] vec_count;
`endif

    shift_add_pipe #(.NUM_INPUTS(N), .BIT_WIDTH(BW), .SHIFT_STEP(SS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef SHIFT_ADD_PIPE_PERF_EN
        .vec_count (vec_count),
`endif
        .bus       (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] vec, input logic dis);
        int n = 0;
        bus.in            = vec;
        bus.disable_stage = dis;
        bus.in_valid      = 1'b1;
        #1;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("send_wait", 32'(n < 100), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic recv(input string tag, input logic [12:0] exp_out, input int exp_lane, input logic exp_byp);
        int n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_wait"}, 32'(n < 100), 1);
        check_eq({tag, "_out"}, 32'(bus.out), 32'(exp_out));
        check_eq({tag, "_lane"}, 32'(bus.out_lane), exp_lane);
        check_eq({tag, "_byp"}, 32'(bus.out_bypass), 32'(exp_byp));
        @(negedge clk);
    endtask

    initial begin
        logic [12:0] bp_exp [4];
        int          hs [4];
        int          got;
        int          seen;
        bp_exp = '{13'h01A, 13'h0F0, 13'h771, 13'h1880};
        hs     = '{0, 0, 0, 0};
        got    = 0;

        bus.in            = '0;
        bus.disable_stage = 1'b0;
        bus.in_valid      = 1'b0;
        bus.out_ready     = 1'b1;

        // reset state
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_valid", 32'(bus.out_valid), 0);
        check_eq("rst_out", 32'(bus.out), 0);
        check_eq("rst_lane", 32'(bus.out_lane), 0);
        check_eq("rst_byp", 32'(bus.out_bypass), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_ready", 32'(bus.in_ready), 1);

        // reduce basic with latency
        send(32'h01010101, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_eq("red_early", 32'(bus.out_valid), 0);
        @(negedge clk);
        check_eq("red_lat", 32'(bus.out_valid), 1);
        recv("red_basic", 13'h00F, 0, 1'b0);
`ifdef SHIFT_ADD_PIPE_PERF_EN
        check_eq("perf_one", 32'(vec_count), 1);
`endif

        // sign extension
        send(32'h000000FF, 1'b0);
        @(negedge clk);
        recv("sext_lo", 13'h1FFF, 0, 1'b0);
        send(32'h80000000, 1'b0);
        @(negedge clk);
        recv("sext_hi", 13'h1C00, 0, 1'b0);

        // bypass
        send(32'h44332211, 1'b1);
        @(negedge clk);
        check_eq("byp_early", 32'(bus.out_valid), 0);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check_eq("byp_ready", 32'(bus.in_ready), 0);
            check_eq("byp_next", 32'(bus.out_valid), 1);
            recv("byp", 13'(8'h11 * (k + 1)), k, 1'b1);
        end
        check_eq("byp_done_ready", 32'(bus.in_ready), 1);

        // backpressure and streaming
        fork
            begin
                send(32'h01020304, 1'b0);
                send(32'h10101010, 1'b0);
                send(32'h7F7F7F7F, 1'b0);
                send(32'h80808080, 1'b0);
            end
            begin
                logic [12:0] held;
                int          cyc = 0;
                int          stall_left = 0;
                bit          started = 0;
                held = '0;
                while (got < 4 && cyc < 60) begin
                    @(negedge clk);
                    cyc++;
                    if (bus.out_valid && !started) begin
                        started    = 1;
                        stall_left = 3;
                        held       = bus.out;
                    end else if (stall_left > 0) begin
                        check_eq("bp_hold_out", 32'(bus.out), 32'(held));
                        check_eq("bp_hold_valid", 32'(bus.out_valid), 1);
                    end
                    if (stall_left > 0) begin
                        bus.out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        bus.out_ready = 1'b1;
                    end
                    if (bus.out_valid && bus.out_ready) begin
                        check_eq("bp_out", 32'(bus.out), 32'(bp_exp[got]));
                        hs[got] = cyc;
                        got++;
                    end
                end
                bus.out_ready = 1'b1;
            end
        join
        check_eq("bp_count", got, 4);
        for (int i = 1; i < 4; i++) begin
            check_eq("bp_rate", 32'(hs[i] - hs[i-1]), 1);
        end
        @(negedge clk);
        check_eq("bp_drained", 32'(bus.out_valid), 0);

        // mode switch
        fork
            begin
                send(32'h01010101, 1'b0);
                bus.in            = 32'h04030201;
                bus.disable_stage = 1'b1;
                bus.in_valid      = 1'b1;
                #1;
                check_eq("ms_block", 32'(bus.in_ready), 0);
                send(32'h04030201, 1'b1);
            end
            begin
                @(negedge clk);
                recv("ms_red", 13'h00F, 0, 1'b0);
                for (int k = 0; k < N; k++) begin
                    recv("ms_byp", 13'(k + 1), k, 1'b1);
                end
            end
        join

        // reset during bypass lane 2
        @(negedge clk);
        send(32'hAABBCCDD, 1'b1);
        @(negedge clk);
        recv("rb_l0", 13'h0DD, 0, 1'b1);
        recv("rb_l1", 13'h0CC, 1, 1'b1);
        check_eq("rb_l2_out", 32'(bus.out), 32'h0BB);
        check_eq("rb_l2_lane", 32'(bus.out_lane), 2);
        rst_n = 1'b0;
        #1;
        check_eq("rb_valid", 32'(bus.out_valid), 0);
        check_eq("rb_byp", 32'(bus.out_bypass), 0);
        check_eq("rb_lane", 32'(bus.out_lane), 0);
`ifdef SHIFT_ADD_PIPE_PERF_EN
        check_eq("rb_perf", 32'(vec_count), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen++;
            end
        end
        check_eq("rb_no_emit", seen, 0);
        check_eq("rb_idle_ready", 32'(bus.in_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
